// File: rtl/crc32_stream_engine_pkg.sv
// crc32_pkg: shared constants, FSM state type and the CRC-32 table generator
// used by the slice ROMs and the streaming engine.
//   POLY_REFL  - reflected IEEE 802.3 polynomial
//   CRC_INIT   - default preset loaded at start of packet
//   CRC_XOROUT - default final XOR
//   state_e    - engine states
//   crc32_tab  - entry idx of the table advanced by 'slice' extra zero bytes
package crc32_pkg;

  localparam logic [31:0] POLY_REFL  = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, RUN, TAIL, DONE} state_e;

  // Classic byte table: CRC of a single byte shifted through eight bit steps.
  function automatic logic [31:0] crc32_byte_tab(input logic [7:0] idx);
    logic [31:0] t;
    t = {24'h0, idx};
    for (int b = 0; b < 8; b++) begin
      t = t[0] ? ((t >> 1) ^ POLY_REFL) : (t >> 1);
    end
    return t;
  endfunction

  // Each extra slice pushes the remainder through one more zero byte.
  function automatic logic [31:0] crc32_tab(input int slice, input int idx);
    logic [31:0] t;
    t = crc32_byte_tab(idx[7:0]);
    for (int k = 0; k < slice; k++) begin
      t = (t >> 8) ^ crc32_byte_tab(t[7:0]);
    end
    return t;
  endfunction

endpackage

// File: rtl/crc32_stream_engine_if.sv
// crc32_stream_engine_if: word input handshake plus CRC result handshake.
//   in_valid/in_ready/in_data/in_sop/in_eop/in_bytes - packet word stream
//   out_valid/out_ready/out_crc/out_len              - one result per packet
//   err_sop                                          - protocol error pulse
// slave is the engine side, master is the source/consumer side.
interface crc32_stream_engine_if #(
  parameter int LEN_W = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_sop;
  logic             in_eop;
  logic [1:0]       in_bytes;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_crc;
  logic [LEN_W-1:0] out_len;
  logic             err_sop;

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, in_bytes, out_ready,
    output in_ready, out_valid, out_crc, out_len, err_sop
  );

  modport master (
    output in_valid, in_data, in_sop, in_eop, in_bytes, out_ready,
    input  in_ready, out_valid, out_crc, out_len, err_sop
  );
endinterface

// File: rtl/crc32_slice_rom.sv
// crc32_slice_rom: 256x32 CRC-32 lookup table for one slice (0..3),
// contents fixed at elaboration, asynchronous read.
//   addr_i - table index
//   data_o - table entry
module crc32_slice_rom
  import crc32_pkg::*;
#(
  parameter int SLICE = 0
) (
  input  logic [7:0]  addr_i,
  output logic [31:0] data_o
);

  logic [31:0] rom [256];

  for (genvar i = 0; i < 256; i++) begin : g_ent
    localparam logic [31:0] ENTRY = crc32_tab(SLICE, i);
    assign rom[i] = ENTRY;
  end

  assign data_o = rom[addr_i];

endmodule

// File: rtl/crc32_stream_engine.sv
// crc32_stream_engine: streaming CRC-32 over 32-bit little-endian words,
// slicing-by-4 for full words, byte-serial finish for partial last words.
//   clk, rst - clock, synchronous active-high reset
//   bus      - slave side of crc32_stream_engine_if (word in, CRC result out)
module crc32_stream_engine
  import crc32_pkg::*;
#(
  parameter int          LEN_W  = 16,
  parameter logic [31:0] INIT   = CRC_INIT,
  parameter logic [31:0] XOROUT = CRC_XOROUT
) (
  input logic clk,
  input logic rst,
  crc32_stream_engine_if.slave bus
);

  state_e           state_q;
  logic [31:0]      crc_q;
  logic [31:0]      tail_q;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       rem_q;
  logic [1:0]       bidx_q;
  logic             out_valid_q;
  logic [31:0]      out_crc_q;
  logic [LEN_W-1:0] out_len_q;
  logic             err_q;

  logic             accept;
  logic [31:0]      word_base;
  logic [31:0]      x;
  logic [LEN_W-1:0] len_base;
  logic [7:0]       tail_byte;
  logic [7:0]       rom0_addr;
  logic [31:0]      t0_data, t1_data, t2_data, t3_data;
  logic [31:0]      word_crc_d;
  logic [31:0]      byte_crc_d;
  logic [LEN_W-1:0] len_word_d;
  logic [LEN_W-1:0] len_byte_d;

  // Saturating byte-count add; the extra carry bit flags overflow.
  function automatic logic [LEN_W-1:0] len_add(input logic [LEN_W-1:0] a,
                                               input logic [2:0] inc);
    logic [LEN_W:0] s;
    s = {1'b0, a} + {{(LEN_W-2){1'b0}}, inc};
    return s[LEN_W] ? '1 : s[LEN_W-1:0];
  endfunction

  assign bus.in_ready  = (state_q == IDLE) || (state_q == RUN);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_crc   = out_crc_q;
  assign bus.out_len   = out_len_q;
  assign bus.err_sop   = err_q;

  // An sop word always restarts from INIT, even in the middle of a packet.
  assign word_base = bus.in_sop ? INIT : crc_q;
  assign len_base  = bus.in_sop ? '0 : len_q;
  assign x         = word_base ^ bus.in_data;
  assign tail_byte = 8'(tail_q >> {bidx_q, 3'b000});

  // T0 is shared: no words are accepted while in TAIL.
  assign rom0_addr = (state_q == TAIL) ? (crc_q[7:0] ^ tail_byte) : x[31:24];

  crc32_slice_rom #(.SLICE(0)) u_t0 (.addr_i(rom0_addr), .data_o(t0_data));
  crc32_slice_rom #(.SLICE(1)) u_t1 (.addr_i(x[23:16]),  .data_o(t1_data));
  crc32_slice_rom #(.SLICE(2)) u_t2 (.addr_i(x[15:8]),   .data_o(t2_data));
  crc32_slice_rom #(.SLICE(3)) u_t3 (.addr_i(x[7:0]),    .data_o(t3_data));

  assign word_crc_d = t3_data ^ t2_data ^ t1_data ^ t0_data;
  assign byte_crc_d = (crc_q >> 8) ^ t0_data;
  assign len_word_d = len_add(len_base, 3'd4);
  assign len_byte_d = len_add(len_q, 3'd1);

  // Partial last word is held here and drained one byte per cycle.
  always_ff @(posedge clk) begin
    if (accept && bus.in_eop && (bus.in_bytes != 2'd0)) begin
      tail_q <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      len_q       <= '0;
      rem_q       <= 2'd0;
      bidx_q      <= 2'd0;
      out_valid_q <= 1'b0;
      out_crc_q   <= '0;
      out_len_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE, RUN: begin
          if (accept) begin
            if ((state_q == IDLE) && !bus.in_sop) begin
              err_q <= 1'b1;
            end else begin
              err_q <= (state_q == RUN) && bus.in_sop;
              if (bus.in_eop && (bus.in_bytes != 2'd0)) begin
                crc_q   <= word_base;
                len_q   <= len_base;
                rem_q   <= bus.in_bytes;
                bidx_q  <= 2'd0;
                state_q <= TAIL;
              end else begin
                crc_q <= word_crc_d;
                len_q <= len_word_d;
                if (bus.in_eop) begin
                  out_valid_q <= 1'b1;
                  out_crc_q   <= word_crc_d ^ XOROUT;
                  out_len_q   <= len_word_d;
                  state_q     <= DONE;
                end else begin
                  state_q <= RUN;
                end
              end
            end
          end
        end
        TAIL: begin
          crc_q  <= byte_crc_d;
          len_q  <= len_byte_d;
          bidx_q <= bidx_q + 2'd1;
          rem_q  <= rem_q - 2'd1;
          if (rem_q == 2'd1) begin
            out_valid_q <= 1'b1;
            out_crc_q   <= byte_crc_d ^ XOROUT;
            out_len_q   <= len_byte_d;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_stream_engine.sv
// tb_crc32_stream_engine: scoreboard bench for crc32_stream_engine with a
// 4-bit length counter so that saturation is reachable.
module tb_crc32_stream_engine;

  localparam int LEN_W = 4;

  typedef struct packed {
    logic [31:0]      crc;
    logic [LEN_W-1:0] len;
  } exp_t;

  logic clk;
  logic rst;
  crc32_stream_engine_if #(.LEN_W(LEN_W)) bus ();

  crc32_stream_engine #(.LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t       sb[$];
  int         checks   = 0;
  int         errors   = 0;
  int         err_cnt  = 0;
  int         rdy_mode = 1;   // 0: out_ready low, 1: high, 2: random
  logic [7:0] pkt [64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-serial bitwise reference CRC-32 over pkt[0..n-1].
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, pkt[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  task automatic load_str(input string s);
    for (int i = 0; i < s.len(); i++) pkt[i] = s[i];
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic s, input logic e,
                           input logic [1:0] nb, output int waited);
    waited = 0;
    bus.in_data  = d;
    bus.in_sop   = s;
    bus.in_eop   = e;
    bus.in_bytes = nb;
    bus.in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 200) begin
        chk("in_ready_wait", 64'(waited), 64'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] ecrc,
                          input logic [LEN_W-1:0] elen, input bit gaps,
                          output int first_wait);
    int nw;
    int w;
    logic [31:0] d;
    nw = (n + 3) / 4;
    sb.push_back('{crc: ecrc, len: elen});
    first_wait = 0;
    for (int i = 0; i < nw; i++) begin
      d = '0;
      for (int b = 0; b < 4; b++) begin
        if (4 * i + b < n) d[8*b +: 8] = pkt[4*i+b];
      end
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
      send_word(d, i == 0, i == nw - 1, 2'(n % 4), w);
      if (i == 0) first_wait = w;
    end
  endtask

  // out_valid must stay low for lat samples after the last accept, then rise.
  task automatic chk_latency(input int lat);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("lat_low", 64'(bus.out_valid), 64'd0);
    end
    @(negedge clk);
    chk("lat_high", 64'(bus.out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Result monitor: every completed output handshake is checked in order.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          chk("out_crc", 64'(bus.out_crc), 64'(e.crc));
          chk("out_len", 64'(bus.out_len), 64'(e.len));
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.err_sop) err_cnt++;
    end
  end

  initial begin
    int w;
    int n;
    logic [LEN_W-1:0] l;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    bus.in_bytes = 2'd0;

    // Reset state, sampled while reset is still asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_err_sop",   64'(bus.err_sop),   64'd0);
    chk("rst_out_crc",   64'(bus.out_crc),   64'd0);
    chk("rst_out_len",   64'(bus.out_len),   64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // "123456789"
    load_str("123456789");
    send_pkt(9, 32'hCBF4_3926, 4'd9, 1'b0, w);
    chk_latency(1);

    // Single zero word, full eop
    for (int i = 0; i < 4; i++) pkt[i] = 8'h00;
    send_pkt(4, 32'h2144_DF1C, 4'd4, 1'b0, w);
    chk_latency(0);

    // Single byte "a"
    pkt[0] = 8'h61;
    send_pkt(1, 32'hE8B7_BE43, 4'd1, 1'b0, w);
    chk_latency(1);

    // Backpressure in DONE
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) pkt[i] = 8'h00;
    send_pkt(4, 32'h2144_DF1C, 4'd4, 1'b0, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready",  64'(bus.in_ready),  64'd0);
      chk("bp_out_crc",   64'(bus.out_crc),   64'h2144_DF1C);
      chk("bp_out_len",   64'(bus.out_len),   64'd4);
    end
    rdy_mode = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    pkt[0] = 8'h61;
    send_pkt(1, 32'hE8B7_BE43, 4'd1, 1'b0, w);
    chk("bp_next_sop_wait", 64'(w), 64'd0);
    chk_latency(1);

    // Non-sop words in IDLE are dropped with an error pulse
    send_word(32'hAAAA_5555, 1'b0, 1'b0, 2'd0, w);
    @(negedge clk);
    chk("idle_err_hi",  64'(bus.err_sop),   64'd1);
    chk("idle_no_out",  64'(bus.out_valid), 64'd0);
    @(negedge clk);
    chk("idle_err_lo",  64'(bus.err_sop),   64'd0);
    @(posedge clk);
    #1;
    send_word(32'h0000_0001, 1'b0, 1'b1, 2'd2, w);
    @(negedge clk);
    chk("idle_eop_err", 64'(bus.err_sop),   64'd1);
    chk("idle_eop_out", 64'(bus.out_valid), 64'd0);
    chk("idle_eop_rdy", 64'(bus.in_ready),  64'd1);
    @(posedge clk);
    #1;

    // sop in the middle of a packet restarts it
    send_word(32'hDEAD_BEEF, 1'b1, 1'b0, 2'd0, w);
    sb.push_back('{crc: 32'hCBF4_3926, len: 4'd9});
    send_word(32'h3433_3231, 1'b1, 1'b0, 2'd0, w);
    @(negedge clk);
    chk("midsop_err_hi", 64'(bus.err_sop), 64'd1);
    @(negedge clk);
    chk("midsop_err_lo", 64'(bus.err_sop), 64'd0);
    @(posedge clk);
    #1;
    send_word(32'h3837_3635, 1'b0, 1'b0, 2'd0, w);
    send_word(32'h0000_0039, 1'b0, 1'b1, 2'd1, w);
    chk_latency(1);

    // Reset while in TAIL
    send_word(32'h1122_3344, 1'b1, 1'b1, 2'd3, w);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tail_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_tail_ready", 64'(bus.in_ready),  64'd1);
    chk("rst_tail_err",   64'(bus.err_sop),   64'd0);
    @(posedge clk);
    #1;
    pkt[0] = 8'h61;
    send_pkt(1, 32'hE8B7_BE43, 4'd1, 1'b0, w);
    chk_latency(1);

    // Reset while in DONE
    rdy_mode = 0;
    send_word(32'h0000_0000, 1'b1, 1'b1, 2'd0, w);
    @(negedge clk);
    chk("pre_rst_done", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_done_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_done_ready", 64'(bus.in_ready),  64'd1);
    chk("rst_done_crc",   64'(bus.out_crc),   64'd0);
    chk("rst_done_len",   64'(bus.out_len),   64'd0);
    rst = 1'b0;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    load_str("123456789");
    send_pkt(9, 32'hCBF4_3926, 4'd9, 1'b0, w);
    chk_latency(1);

    // Random packets with input gaps and random consumer stalls
    rdy_mode = 2;
    for (int p = 0; p < 30; p++) begin
      n = (p == 0) ? 64 : $urandom_range(1, 64);
      for (int i = 0; i < n; i++) pkt[i] = 8'($urandom);
      l = (n > 15) ? 4'd15 : 4'(n);
      send_pkt(n, ref_crc(n), l, 1'b1, w);
    end
    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("sb_drain", 64'(sb.size()), 64'd0);
    chk("err_sop_count", 64'(err_cnt), 64'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
